sp_ram_banked: RTL and testbench

Parametrised single-port RAM built from a ROWS x COLS array of RA1SHD macros (4096 x 8 each). It is the generalised successor of the fixed 2x4 core memory. It adds a req/gnt/rvalid handshake, a hardware zero-clear state machine (run at reset and on demand), and an optional output register stage. It sits between the core's instruction/data ports and the SRAM macros.

---
 rtl/sp_ram_pkg.sv | 10 +
 rtl/RA1SHD.sv | 21 ++
 rtl/sp_ram_row.sv | 29 ++
 rtl/sp_ram_banked.sv | 152 +++++++++++++++
 tb/tb_sp_ram_banked.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/sp_ram_pkg.sv
// Shared constants and types for the banked single-port RAM.
//   MACRO_DEPTH/MACRO_ADDR_WIDTH/MACRO_WIDTH: geometry of one RA1SHD macro
//   sp_ram_state_e: zero-clear / operational FSM states
package sp_ram_pkg;
  localparam int unsigned MACRO_DEPTH      = 4096;
  localparam int unsigned MACRO_ADDR_WIDTH = 12;
  localparam int unsigned MACRO_WIDTH      = 8;

  typedef enum logic {CLEAR, READY} sp_ram_state_e;
endpackage

// File: rtl/RA1SHD.sv
// Behavioural model of the RA1SHD 4096 x 8 single-port SRAM macro.
//   CLK: clock, CEN: chip enable (active low), WEN: write enable (active low)
//   A: address, D: write data, Q: registered read data (holds across writes)
module RA1SHD (
  input  logic       CLK,
  input  logic       CEN,
  input  logic       WEN,
  input  logic [11:0] A,
  input  logic [7:0] D,
  output logic [7:0] Q
);
  logic [7:0] mem [4096];

  // Synchronous write or read on an enabled cycle
  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!WEN) mem[A] <= D;
      else      Q      <= mem[A];
    end
  end
endmodule

// File: rtl/sp_ram_row.sv
// One row of COLS byte-wide RA1SHD macros sharing address and enable.
//   clk: clock, en: row enable (active high), we: per-byte write enables
//   addr: macro address, wdata: row write data, q: row read data
module sp_ram_row
  import sp_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        en,
  input  logic [DATA_WIDTH/8-1:0]     we,
  input  logic [MACRO_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  output logic [DATA_WIDTH-1:0]       q
);
  localparam int unsigned COLS = DATA_WIDTH / MACRO_WIDTH;

  // Enabled macros with their write enable low perform a harmless read
  for (genvar c = 0; c < COLS; c++) begin : g_col
    RA1SHD u_mac (
      .CLK (clk),
      .CEN (~en),
      .WEN (~we[c]),
      .A   (addr),
      .D   (wdata[c*MACRO_WIDTH +: MACRO_WIDTH]),
      .Q   (q[c*MACRO_WIDTH +: MACRO_WIDTH])
    );
  end
endmodule

// File: rtl/sp_ram_banked.sv
// Banked single-port RAM: ROWS x COLS RA1SHD macros with req/gnt/rvalid
// handshake and a hardware zero-clear run at reset and on clear_i.
// Optional feature macro: SP_RAM_OUT_REG_EN adds an output register (latency 2).
//   clk, rst (async active high), clear_i: request zero-clear in READY
//   req_i/gnt_o: request handshake, we_i/be_i/addr_i/wdata_i: access fields
//   rvalid_o/rdata_o: one response per accepted request
//   init_done_o: high while operational
module sp_ram_banked
  import sp_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 8192,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    init_done_o
);
  localparam int unsigned COLS      = DATA_WIDTH / MACRO_WIDTH;
  localparam int unsigned ROWS      = NUM_WORDS / MACRO_DEPTH;
  localparam int unsigned ROW_SEL_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  sp_ram_state_e               state;
  logic [MACRO_ADDR_WIDTH-1:0] clr_addr;
  logic                        accept;
  logic [ROW_SEL_W-1:0]        row_sel;

  logic [ROWS-1:0]             row_en;
  logic [COLS-1:0]             row_we [ROWS];
  logic [DATA_WIDTH-1:0]       row_q  [ROWS];
  logic [MACRO_ADDR_WIDTH-1:0] mac_addr;
  logic [DATA_WIDTH-1:0]       mac_wdata;

  logic                        rsp_valid;
  logic                        rsp_we;
  logic [ROW_SEL_W-1:0]        rsp_row;
  logic [DATA_WIDTH-1:0]       rdata_c;

  assign gnt_o       = (state == READY);
  assign init_done_o = (state == READY);
  assign accept      = req_i & gnt_o;

  // Row select from the top address bits; a single row needs none
  if (ROWS > 1) begin : g_row_sel
    assign row_sel = addr_i[ADDR_WIDTH-1 -: ROW_SEL_W];
  end else begin : g_row_one
    assign row_sel = '0;
  end

  // Clear sweep and READY/CLEAR sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + MACRO_ADDR_WIDTH'(1);
          if (clr_addr == MACRO_ADDR_WIDTH'(MACRO_DEPTH - 1)) state <= READY;
        end
        READY: begin
          if (clear_i) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Macro controls: clear writes zeros everywhere, otherwise only the selected row
  always_comb begin
    mac_addr  = addr_i[MACRO_ADDR_WIDTH-1:0];
    mac_wdata = wdata_i;
    row_en    = '0;
    for (int unsigned r = 0; r < ROWS; r++) row_we[r] = '0;
    if (state == CLEAR) begin
      mac_addr  = clr_addr;
      mac_wdata = '0;
      row_en    = '1;
      for (int unsigned r = 0; r < ROWS; r++) row_we[r] = '1;
    end else if (accept) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (row_sel == ROW_SEL_W'(r)) begin
          row_en[r] = 1'b1;
          if (we_i) row_we[r] = be_i;
        end
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    sp_ram_row #(.DATA_WIDTH(DATA_WIDTH)) u_row (
      .clk   (clk),
      .en    (row_en[r]),
      .we    (row_we[r]),
      .addr  (mac_addr),
      .wdata (mac_wdata),
      .q     (row_q[r])
    );
  end

  // Response tracking: which row to return and whether it was a read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_row   <= '0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_we  <= we_i;
        rsp_row <= row_sel;
      end
    end
  end

  // Row mux of macro Q, zero unless a read response is presented
  always_comb begin
    rdata_c = '0;
    if (rsp_valid && !rsp_we) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (rsp_row == ROW_SEL_W'(r)) rdata_c = row_q[r];
      end
    end
  end

`ifdef SP_RAM_OUT_REG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= rsp_valid;
      rdata_o  <= rdata_c;
    end
  end
`else
  assign rvalid_o = rsp_valid;
  assign rdata_o  = rdata_c;
`endif
endmodule

// File: tb/tb_sp_ram_banked.sv
// Scoreboard bench for sp_ram_banked: stimulus pushes expected responses,
// a negedge monitor pops and compares data and arrival cycle.
module tb_sp_ram_banked;
`ifdef SP_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_i;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [3:0]  be_i;
  logic [12:0] addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        init_done_o;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  sp_ram_banked dut (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .we_i        (we_i),
    .be_i        (be_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .init_done_o (init_done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (!rst && rvalid_o) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rvalid: got rdata %h, expected no response (cycle %0d)", rdata_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", rdata_o, e.data);
        chk("rvalid_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // One-cycle access issued at a drive point (#1 after posedge)
  task automatic access(input logic we, input logic [3:0] be, input logic [12:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp,
                        input logic clr, input logic push);
    req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wd; clear_i = clr;
    #1;
    chk("gnt_on_req", {31'd0, gnt_o}, 32'd1);
    if (push) sb.push_back('{data: exp, due: cyc + LAT});
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0; clear_i = 1'b0; be_i = 4'h0;
  endtask

  // Hold a read request through the zero-clear and expect no grant for 4096 cycles
  task automatic wait_clear(input string tag);
    int bad = 0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 13'h0000;
    for (int i = 0; i < 4096; i++) begin
      if (gnt_o !== 1'b0 || init_done_o !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    req_i = 1'b0;
    chk({tag, "_gnt_during_clear"}, 32'(bad), 32'd0);
    chk({tag, "_gnt_after_clear"}, {31'd0, gnt_o}, 32'd1);
    chk({tag, "_init_done"}, {31'd0, init_done_o}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; clear_i = 1'b0; req_i = 1'b0; we_i = 1'b0;
    be_i = 4'h0; addr_i = '0; wdata_i = '0;
    #1;
    chk("rst_gnt",       {31'd0, gnt_o},       32'd0);
    chk("rst_rvalid",    {31'd0, rvalid_o},    32'd0);
    chk("rst_rdata",     rdata_o,              32'd0);
    chk("rst_init_done", {31'd0, init_done_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_clear("reset");

    // Freshly cleared contents, both rows including the top address
    access(1'b0, 4'h0, 13'h0123, 32'h0, 32'h00000000, 1'b0, 1'b1);
    access(1'b0, 4'h0, 13'h1FFF, 32'h0, 32'h00000000, 1'b0, 1'b1);

    // Write then immediate read of the same address
    access(1'b1, 4'hF, 13'h0005, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    access(1'b0, 4'h0, 13'h0005, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);

    // Partial byte write in row 1 at the same macro address
    access(1'b1, 4'hF, 13'h1005, 32'h11223344, 32'h0, 1'b0, 1'b1);
    access(1'b1, 4'h5, 13'h1005, 32'hAABBCCDD, 32'h0, 1'b0, 1'b1);
    access(1'b0, 4'h0, 13'h1005, 32'h0, 32'h11BB33DD, 1'b0, 1'b1);
    access(1'b0, 4'h0, 13'h0005, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    repeat (2) @(posedge clk); #1;

    // Back-to-back reads across rows
    access(1'b0, 4'h0, 13'h0005, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    access(1'b0, 4'h0, 13'h1005, 32'h0, 32'h11BB33DD, 1'b0, 1'b1);
    repeat (3) @(posedge clk); #1;

    // Read accepted with clear_i still returns old data
    access(1'b0, 4'h0, 13'h1005, 32'h0, 32'h11BB33DD, 1'b1, 1'b1);
    chk("clear_gnt_drop",       {31'd0, gnt_o},       32'd0);
    chk("clear_init_done_drop", {31'd0, init_done_o}, 32'd0);
    wait_clear("clear");
    access(1'b0, 4'h0, 13'h1005, 32'h0, 32'h00000000, 1'b0, 1'b1);
    access(1'b0, 4'h0, 13'h0005, 32'h0, 32'h00000000, 1'b0, 1'b1);

    // Reset two cycles after an accepted read
    access(1'b1, 4'hF, 13'h0005, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
    access(1'b0, 4'h0, 13'h0005, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
    repeat (3) @(posedge clk); #1;
    access(1'b0, 4'h0, 13'h0005, 32'h0, 32'hCAFEF00D, 1'b0, (LAT == 1));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("midrst_gnt",    {31'd0, gnt_o},    32'd0);
    chk("midrst_rdata",  rdata_o,           32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_clear("midrst");
    access(1'b0, 4'h0, 13'h0005, 32'h0, 32'h00000000, 1'b0, 1'b1);

    repeat (5) @(posedge clk); #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
